// File: rtl/nic_pkg.sv
// Shared constants for the network interface controller: data width, VC bit and
// processor register map.
package nic_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned VC_BIT = DATA_W - 1;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_IN_DATA  = 2'b00;
  localparam logic [ADDR_W-1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [ADDR_W-1:0] ADDR_OUT_DATA = 2'b10;
  localparam logic [ADDR_W-1:0] ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_chan_buf.sv
// Single-entry channel buffer: data register plus full flag.
// Load and clear are mutually exclusive by construction in the parent.
module nic_chan_buf
  import nic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              full
);

  // Data persists after clear so a later read of an empty buffer returns stale contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/nic.sv
// Network interface controller: processor register port on one side, router
// ready/send handshake gated by VC polarity on the other.
module nic
  import nic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);

  logic [DATA_W-1:0] in_buf;
  logic [DATA_W-1:0] out_buf;
  logic              in_full;
  logic              out_full;
  logic              proc_rd;
  logic              proc_wr;
  logic              in_load;
  logic              in_clear;
  logic              out_load;

  assign proc_rd  = nicEn & ~nicWrEn;
  assign proc_wr  = nicEn & nicWrEn;

  // Drain only when the buffer actually holds a packet; a receive is then impossible.
  assign in_clear = proc_rd & (addr == ADDR_IN_DATA) & in_full;
  assign in_load  = net_si & ~in_full;

  // No bypass: a write during a send sees out_full=1 and is dropped.
  assign out_load = proc_wr & (addr == ADDR_OUT_DATA) & ~out_full;

  assign net_so = out_full & net_ro & (out_buf[VC_BIT] == ~net_polarity);
  assign net_do = out_buf;
  assign net_ri = ~in_full;

  nic_chan_buf u_in_buf (
    .clk   (clk),
    .reset (reset),
    .load  (in_load),
    .clear (in_clear),
    .d     (net_di),
    .q     (in_buf),
    .full  (in_full)
  );

  nic_chan_buf u_out_buf (
    .clk   (clk),
    .reset (reset),
    .load  (out_load),
    .clear (net_so),
    .d     (d_in),
    .q     (out_buf),
    .full  (out_full)
  );

  // Combinational register read; output data register reads as zero.
  always_comb begin
    d_out = '0;
    if (proc_rd) begin
      case (addr)
        ADDR_IN_DATA:  d_out = in_buf;
        ADDR_IN_STAT:  d_out = DATA_W'(in_full);
        ADDR_OUT_STAT: d_out = DATA_W'(out_full);
        default:       d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nic.sv
// Directed self-checking bench for nic with hand-computed expected values.
module tb_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b00;
    d_in = '0; net_ro = 1'b0; net_polarity = 1'b0;
    net_si = 1'b0; net_di = 64'hFEDCBA9876543210;
    #15;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_d_out", d_out, 64'h0);
    chk("rst_net_ri", 64'(net_ri), 64'h1);
    chk("rst_net_so", 64'(net_so), 64'h0);
    chk("rst_net_do", net_do, 64'h0);

    // Processor write into output buffer, router not ready
    addr = 2'b10; nicWrEn = 1'b1; d_in = 64'h0123456789ABCDEF;
    chk("wr_d_out_zero", d_out, 64'h0);
    tick();
    nicWrEn = 1'b0; addr = 2'b11; #1;
    chk("wr_out_full", d_out, 64'h1);
    chk("wr_net_so", 64'(net_so), 64'h0);
    chk("wr_net_do", net_do, 64'h0123456789ABCDEF);
    addr = 2'b10; #1;
    chk("rd_addr10_zero", d_out, 64'h0);

    // Send with matching polarity, concurrent write dropped
    net_ro = 1'b1; net_polarity = 1'b1;
    nicWrEn = 1'b1; d_in = 64'h1111111111111111; #1;
    chk("send_net_so", 64'(net_so), 64'h1);
    tick();
    net_ro = 1'b0; #1;
    chk("send_drop_do", net_do, 64'h0123456789ABCDEF);
    chk("send_after_so", 64'(net_so), 64'h0);
    tick();
    nicWrEn = 1'b0; addr = 2'b11; #1;
    chk("late_load_do", net_do, 64'h1111111111111111);
    chk("late_load_full", d_out, 64'h1);

    // Drain it, then load a VC=1 packet
    net_ro = 1'b1; #1;
    chk("drain_so", 64'(net_so), 64'h1);
    tick();
    net_ro = 1'b0; addr = 2'b10; nicWrEn = 1'b1; d_in = 64'h8000000000000001;
    tick();
    nicWrEn = 1'b0; addr = 2'b11; net_ro = 1'b1; net_polarity = 1'b1; #1;
    chk("vc1_blocked_so", 64'(net_so), 64'h0);
    tick();
    chk("vc1_still_full", d_out, 64'h1);
    net_polarity = 1'b0; #1;
    chk("vc1_pol0_so", 64'(net_so), 64'h1);
    tick();
    chk("vc1_emptied", d_out, 64'h0);
    chk("vc1_so_low", 64'(net_so), 64'h0);
    net_ro = 1'b0;

    // Router receive
    addr = 2'b01; net_si = 1'b1; net_di = 64'hFEDCBA9876543210;
    tick();
    net_si = 1'b1; net_di = 64'h1010101010101010; #1;
    chk("rx_net_ri", 64'(net_ri), 64'h0);
    chk("rx_in_full", d_out, 64'h1);
    tick();
    net_si = 1'b0; addr = 2'b00; #1;
    chk("rx_rd_data", d_out, 64'hFEDCBA9876543210);
    tick();
    chk("rx_ri_after_rd", 64'(net_ri), 64'h1);
    chk("rx_stale_rd", d_out, 64'hFEDCBA9876543210);
    addr = 2'b01; #1;
    chk("rx_in_empty", d_out, 64'h0);
    nicEn = 1'b0; addr = 2'b00; #1;
    chk("disabled_d_out", d_out, 64'h0);
    nicEn = 1'b1; addr = 2'b01;

    // Fill both buffers, then reset
    net_si = 1'b1; net_di = 64'h1010101010101010;
    addr = 2'b10; nicWrEn = 1'b1; d_in = 64'h2222222222222222;
    tick();
    net_si = 1'b0; nicWrEn = 1'b0; addr = 2'b11; #1;
    chk("full_out", d_out, 64'h1);
    chk("full_in_ri", 64'(net_ri), 64'h0);
    reset = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h3333333333333333;
    tick();
    reset = 1'b0; nicWrEn = 1'b0; addr = 2'b11; #1;
    chk("rst2_out_full", d_out, 64'h0);
    chk("rst2_net_ri", 64'(net_ri), 64'h1);
    chk("rst2_net_do", net_do, 64'h0);
    addr = 2'b00; #1;
    chk("rst2_in_buf", d_out, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
